// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
// riscv_pipe_pkg : shared widths and control bundle for the pipeline stages
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int REG_IDX_W = 5;
   localparam int ALU_OP_W  = 4;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_src;
      logic                mem_read;
      logic                mem_write;
      logic                reg_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// ============================================================================
// load_use_detect : flags an ID instruction that reads the rd of a load in EX
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_use_detect
   import riscv_pipe_pkg::*;
(
   input  logic                 ex_valid_i,
   input  logic                 ex_mem_read_i,
   input  logic [REG_IDX_W-1:0] ex_rd_i,
   input  logic                 id_valid_i,
   input  logic [REG_IDX_W-1:0] id_r1_i,
   input  logic [REG_IDX_W-1:0] id_r2_i,
   output logic                 load_use_o
);

   // x0 is hardwired to zero, so a load targeting it can never create a dependency
   assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                       ((ex_rd_i == id_r1_i) | (ex_rd_i == id_r2_i));

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use bubble insertion and a
//               saturating bubble counter. Optional ID_EX_WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 id_valid_i,
   input  logic [REG_IDX_W-1:0] id_r1_i,
   input  logic [REG_IDX_W-1:0] id_r2_i,
   input  logic [REG_IDX_W-1:0] id_rd_i,
   input  logic [XLEN-1:0]      id_reg1_i,
   input  logic [XLEN-1:0]      id_reg2_i,
   input  logic [XLEN-1:0]      id_imm_i,
   input  logic [XLEN-1:0]      id_pc_i,
   input  logic [ALU_OP_W-1:0]  id_alu_op_i,
   input  logic                 id_alu_src_i,
   input  logic                 id_mem_read_i,
   input  logic                 id_mem_write_i,
   input  logic                 id_reg_write_i,
   input  logic                 flush_i,
   input  logic                 hold_i,
   input  logic                 wb_reg_write_i,
   input  logic [REG_IDX_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]      wb_data_i,
   output logic                 ex_valid_o,
   output logic [REG_IDX_W-1:0] ex_r1_o,
   output logic [REG_IDX_W-1:0] ex_r2_o,
   output logic [REG_IDX_W-1:0] ex_rd_o,
   output logic [XLEN-1:0]      ex_reg1_o,
   output logic [XLEN-1:0]      ex_reg2_o,
   output logic [XLEN-1:0]      ex_imm_o,
   output logic [XLEN-1:0]      ex_pc_o,
   output logic [ALU_OP_W-1:0]  ex_alu_op_o,
   output logic                 ex_alu_src_o,
   output logic                 ex_mem_read_o,
   output logic                 ex_mem_write_o,
   output logic                 ex_reg_write_o,
   output logic                 stall_o,
   output logic [CNT_W-1:0]     bubble_cnt_o
);

   logic                 valid_q, valid_d;
   logic [REG_IDX_W-1:0] r1_q, r1_d, r2_q, r2_d, rd_q, rd_d;
   logic [XLEN-1:0]      reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d, pc_q, pc_d;
   ctrl_t                ctrl_q, ctrl_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 w_load_use;
   logic [XLEN-1:0]      w_op1, w_op2;
   ctrl_t                w_id_ctrl;

   load_use_detect u_load_use_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rd_i       (rd_q),
      .id_valid_i    (id_valid_i),
      .id_r1_i       (id_r1_i),
      .id_r2_i       (id_r2_i),
      .load_use_o    (w_load_use)
   );

   assign stall_o = w_load_use & ~flush_i;

`ifdef ID_EX_WB_BYPASS_EN
   // Same-cycle register-file write/read: take the value being written back
   assign w_op1 = (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == id_r1_i)) ? wb_data_i : id_reg1_i;
   assign w_op2 = (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == id_r2_i)) ? wb_data_i : id_reg2_i;
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_reg_write_i, wb_rd_i, wb_data_i};
   assign w_op1       = id_reg1_i;
   assign w_op2       = id_reg2_i;
`endif

   assign w_id_ctrl = '{alu_op:    id_alu_op_i,
                        alu_src:   id_alu_src_i,
                        mem_read:  id_mem_read_i,
                        mem_write: id_mem_write_i,
                        reg_write: id_reg_write_i};

   always_comb begin
      valid_d = valid_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      rd_d    = rd_q;
      reg1_d  = reg1_q;
      reg2_d  = reg2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (hold_i && !flush_i) begin
         // frozen: keep everything
      end else if (flush_i || w_load_use) begin
         valid_d = 1'b0;
         r1_d    = '0;
         r2_d    = '0;
         rd_d    = '0;
         reg1_d  = '0;
         reg2_d  = '0;
         imm_d   = '0;
         pc_d    = '0;
         ctrl_d  = CTRL_NOP;
         if (!flush_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         valid_d = id_valid_i;
         r1_d    = id_r1_i;
         r2_d    = id_r2_i;
         rd_d    = id_rd_i;
         reg1_d  = w_op1;
         reg2_d  = w_op2;
         imm_d   = id_imm_i;
         pc_d    = id_pc_i;
         ctrl_d  = id_valid_i ? w_id_ctrl : CTRL_NOP;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         r1_q    <= '0;
         r2_q    <= '0;
         rd_q    <= '0;
         reg1_q  <= '0;
         reg2_q  <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ctrl_q  <= CTRL_NOP;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         rd_q    <= rd_d;
         reg1_q  <= reg1_d;
         reg2_q  <= reg2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid_o     = valid_q;
   assign ex_r1_o        = r1_q;
   assign ex_r2_o        = r2_q;
   assign ex_rd_o        = rd_q;
   assign ex_reg1_o      = reg1_q;
   assign ex_reg2_o      = reg2_q;
   assign ex_imm_o       = imm_q;
   assign ex_pc_o        = pc_q;
   assign ex_alu_op_o    = ctrl_q.alu_op;
   assign ex_alu_src_o   = ctrl_q.alu_src;
   assign ex_mem_read_o  = ctrl_q.mem_read;
   assign ex_mem_write_o = ctrl_q.mem_write;
   assign ex_reg_write_o = ctrl_q.reg_write;
   assign bubble_cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : scoreboard bench for id_ex_stage (2-bit counter build)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

   localparam int CW = 2;

   typedef struct packed {
      logic        v;
      logic [4:0]  r1, r2, rd;
      logic [31:0] reg1, reg2, imm, pc;
      logic [3:0]  op;
      logic        src, mr, mw, rw;
   } id_t;

   typedef struct packed {
      logic        v;
      logic [4:0]  r1, r2, rd;
      logic [31:0] reg1, reg2, imm, pc;
      logic [3:0]  op;
      logic        src, mr, mw, rw;
      logic [CW-1:0] cnt;
   } ex_t;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   id_t  id_in = '0;
   logic flush_i = 1'b0, hold_i = 1'b0;
   logic wb_reg_write_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic [31:0] wb_data_i = '0;

   logic        ex_valid_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, stall_o;
   logic [4:0]  ex_r1_o, ex_r2_o, ex_rd_o;
   logic [31:0] ex_reg1_o, ex_reg2_o, ex_imm_o, ex_pc_o;
   logic [3:0]  ex_alu_op_o;
   logic [CW-1:0] bubble_cnt_o;

   int n_pass = 0, n_total = 0;
   ex_t  ex_q[$];
   logic stall_q[$];
   string name_q[$];
   string sname_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .id_valid_i(id_in.v), .id_r1_i(id_in.r1), .id_r2_i(id_in.r2), .id_rd_i(id_in.rd),
      .id_reg1_i(id_in.reg1), .id_reg2_i(id_in.reg2), .id_imm_i(id_in.imm), .id_pc_i(id_in.pc),
      .id_alu_op_i(id_in.op), .id_alu_src_i(id_in.src), .id_mem_read_i(id_in.mr),
      .id_mem_write_i(id_in.mw), .id_reg_write_i(id_in.rw),
      .flush_i(flush_i), .hold_i(hold_i),
      .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_valid_o(ex_valid_o), .ex_r1_o(ex_r1_o), .ex_r2_o(ex_r2_o), .ex_rd_o(ex_rd_o),
      .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
      .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o), .ex_mem_read_o(ex_mem_read_o),
      .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o),
      .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   function automatic ex_t dut_ex();
      return '{v: ex_valid_o, r1: ex_r1_o, r2: ex_r2_o, rd: ex_rd_o,
               reg1: ex_reg1_o, reg2: ex_reg2_o, imm: ex_imm_o, pc: ex_pc_o,
               op: ex_alu_op_o, src: ex_alu_src_o, mr: ex_mem_read_o,
               mw: ex_mem_write_o, rw: ex_reg_write_o, cnt: bubble_cnt_o};
   endfunction

   function automatic ex_t cap(id_t i, logic [CW-1:0] c);
      ex_t e;
      e = '{v: i.v, r1: i.r1, r2: i.r2, rd: i.rd, reg1: i.reg1, reg2: i.reg2,
            imm: i.imm, pc: i.pc, op: i.op, src: i.src, mr: i.mr, mw: i.mw,
            rw: i.rw, cnt: c};
      if (!i.v) begin
         e.op = '0; e.src = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.rw = 1'b0;
      end
      return e;
   endfunction

   function automatic ex_t bub(logic [CW-1:0] c);
      ex_t e;
      e = '0;
      e.cnt = c;
      return e;
   endfunction

   task automatic check_ex(string nm, ex_t exp);
      ex_t act;
      act = dut_ex();
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: ex state got %h expected %h", nm, act, exp);
   endtask

   // Monitors: stall is checked mid-cycle, EX state just after the edge
   initial forever begin
      @(negedge clk);
      if (stall_q.size() != 0) begin
         logic es;
         string nm;
         es = stall_q.pop_front();
         nm = sname_q.pop_front();
         n_total++;
         if (stall_o === es) n_pass++;
         else $display("FAIL %s: stall_o got %b expected %b", nm, stall_o, es);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() != 0) check_ex(name_q.pop_front(), ex_q.pop_front());
   end

   ex_t last;

   task automatic step(string nm, id_t i, logic fl, logic hd, logic wbe,
                       logic exp_stall, ex_t exp);
      @(posedge clk);
      #3;
      id_in   = i;
      flush_i = fl;
      hold_i  = hd;
      wb_reg_write_i = wbe;
      wb_rd_i   = wbe ? 5'd7 : 5'd0;
      wb_data_i = wbe ? 32'hDEADBEEF : 32'h0;
      stall_q.push_back(exp_stall);
      sname_q.push_back(nm);
      ex_q.push_back(exp);
      name_q.push_back(nm);
      last = exp;
   endtask

   localparam id_t LW5   = '{1'b1, 5'd1, 5'd2, 5'd5,  32'h1000, 32'h22, 32'h8,  32'h100, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam id_t ADD6  = '{1'b1, 5'd5, 5'd3, 5'd6,  32'h55,   32'h33, 32'h0,  32'h104, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t LW0   = '{1'b1, 5'd0, 5'd0, 5'd0,  32'h0,    32'h0,  32'h4,  32'h108, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam id_t ADD5  = '{1'b1, 5'd0, 5'd0, 5'd5,  32'h0,    32'h0,  32'h0,  32'h10C, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t SUB7  = '{1'b1, 5'd4, 5'd5, 5'd7,  32'h44,   32'h5,  32'h0,  32'h110, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t LW9   = '{1'b1, 5'd2, 5'd0, 5'd9,  32'h2000, 32'h0,  32'h10, 32'h114, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam id_t DEP9  = '{1'b1, 5'd9, 5'd1, 5'd10, 32'h1,    32'h2,  32'h0,  32'h118, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t DEP9B = '{1'b1, 5'd3, 5'd9, 5'd11, 32'h3,    32'h9,  32'h0,  32'h11C, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t HA    = '{1'b1, 5'd1, 5'd2, 5'd12, 32'hA,    32'hB,  32'h0,  32'h120, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam id_t STX   = '{1'b1, 5'd3, 5'd4, 5'd13, 32'h33,   32'h44, 32'h7,  32'h130, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam id_t INV   = '{1'b0, 5'd3, 5'd4, 5'd3,  32'h77,   32'h88, 32'h9,  32'h134, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam id_t BYP   = '{1'b1, 5'd6, 5'd7, 5'd14, 32'h6,    32'h0,  32'h0,  32'h140, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      ex_t e;
      logic [CW-1:0] c;
      #2;
      check_ex("reset_state", bub('0));
      #1 reset_i = 1'b0;

      step("lw5_capture",     LW5,   1'b0, 1'b0, 1'b0, 1'b0, cap(LW5, 2'd0));
      step("loaduse_bubble",  ADD6,  1'b0, 1'b0, 1'b0, 1'b1, bub(2'd1));
      step("dependent_enter", ADD6,  1'b0, 1'b0, 1'b0, 1'b0, cap(ADD6, 2'd1));
      step("lw_rd0",          LW0,   1'b0, 1'b0, 1'b0, 1'b0, cap(LW0, 2'd1));
      step("rd0_no_stall",    ADD5,  1'b0, 1'b0, 1'b0, 1'b0, cap(ADD5, 2'd1));
      step("nonload_r2",      SUB7,  1'b0, 1'b0, 1'b0, 1'b0, cap(SUB7, 2'd1));
      step("lw9_capture",     LW9,   1'b0, 1'b0, 1'b0, 1'b0, cap(LW9, 2'd1));
      step("flush_priority",  DEP9B, 1'b1, 1'b0, 1'b0, 1'b0, bub(2'd1));
      step("lw9_again",       LW9,   1'b0, 1'b0, 1'b0, 1'b0, cap(LW9, 2'd1));
      step("hold1_loaduse",   DEP9,  1'b0, 1'b1, 1'b0, 1'b1, last);
      step("hold2_loaduse",   DEP9B, 1'b0, 1'b1, 1'b0, 1'b1, last);
      step("hold3_nodep",     HA,    1'b0, 1'b1, 1'b0, 1'b0, last);
      step("hold_release",    STX,   1'b0, 1'b0, 1'b0, 1'b0, cap(STX, 2'd1));
      step("invalid_capture", INV,   1'b0, 1'b0, 1'b0, 1'b0, cap(INV, 2'd1));
      e = cap(BYP, 2'd1);
`ifdef ID_EX_WB_BYPASS_EN
      e.reg2 = 32'hDEADBEEF;
`endif
      step("wb_bypass",       BYP,   1'b0, 1'b0, 1'b1, 1'b0, e);

      c = 2'd1;
      for (int k = 0; k < 3; k++) begin
         c = (k == 2) ? 2'd3 : c + 2'd1;
         step("sat_lw",     LW5,  1'b0, 1'b0, 1'b0, 1'b0, cap(LW5, (k == 0) ? 2'd1 : ((k == 1) ? 2'd2 : 2'd3)));
         step("sat_bubble", ADD6, 1'b0, 1'b0, 1'b0, 1'b1, bub(c));
      end
      step("preload_ex", LW5, 1'b0, 1'b0, 1'b0, 1'b0, cap(LW5, 2'd3));

      @(posedge clk);
      #3;
      reset_i = 1'b1;
      #1;
      check_ex("async_reset", bub('0));
      reset_i = 1'b0;

      @(posedge clk);
      #3;
      n_total++;
      if (ex_q.size() == 0 && stall_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d ex and %0d stall expectations left, expected 0",
                    ex_q.size(), stall_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, expected end of stimulus");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with load-use hazard detection. It sits between the decode stage and the execute-stage forward unit. It latches register indices, operand data, immediate, PC and control from decode, then presents them to the forward unit and ALU. It inserts one bubble when a load in EX feeds the instruction in ID. It also counts the bubbles it inserts.

Parameters:
XLEN, 32, data/PC width
CNT_W, 16, width of bubble performance counter

Ports:
clk_i  in  1  pipeline clock
reset_i  in  1  asynchronous, active-high reset
id_valid_i  in  1  decode holds a real instruction
id_r1_i  in  5  source register 1 index
id_r2_i  in  5  source register 2 index
id_rd_i  in  5  destination register index
id_reg1_i  in  XLEN  register-file read data 1
id_reg2_i  in  XLEN  register-file read data 2
id_imm_i  in  XLEN  decoded immediate
id_pc_i  in  XLEN  instruction PC
id_alu_op_i  in  4  ALU operation
id_alu_src_i  in  1  ALU operand-B select (1 = immediate)
id_mem_read_i  in  1  load
id_mem_write_i  in  1  store
id_reg_write_i  in  1  writes rd
flush_i  in  1  branch/jump taken; squash ID instruction
hold_i  in  1  downstream freeze (memory wait)
wb_reg_write_i  in  1  writeback writes a register (optional feature)
wb_rd_i  in  5  writeback destination (optional feature)
wb_data_i  in  XLEN  writeback data (optional feature)
ex_valid_o  out  1  EX holds a real instruction
ex_r1_o, ex_r2_o, ex_rd_o  out  5 each  registered indices, to forward unit
ex_reg1_o, ex_reg2_o  out  XLEN each  registered operands, to forward unit
ex_imm_o, ex_pc_o  out  XLEN each  registered immediate/PC
ex_alu_op_o  out  4  registered control
ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o  out  1 each  registered control
stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, immediate): all ex_* outputs = 0 (the stage holds a NOP with rd = x0); bubble_cnt_o = 0. stall_o is combinational, so it reads 0 because ex_mem_read_o = 0.
- Hazard (combinational): load_use = ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_r1_i) | (ex_rd_o == id_r2_i)).
- stall_o = load_use & ~flush_i.
- Per rising edge, first match wins:
  1. hold_i & ~flush_i: all ex_* keep their values; counter unchanged.
  2. flush_i: load a bubble. ex_valid_o = 0; all control and indices = 0; data fields don't-care (implement as 0).
  3. load_use: load a bubble; bubble_cnt_o += 1, saturating at 2^CNT_W-1. The ID instruction is held upstream and re-enters next cycle, when the load has moved on, so stall_o lasts exactly 1 cycle per load-use.
  4. Otherwise, capture all id_* into ex_*. ex_valid_o = id_valid_i. If id_valid_i = 0, control is zeroed.
- flush_i with load_use in the same cycle: flush wins, stall_o = 0, no count.
- hold_i with load_use: hold wins for the register. stall_o still follows load_use, which is consistent because upstream is frozen by hold too.
- rd = x0 never triggers a stall.
- Latency: one cycle, ID to EX.
- No wrap-around on the counter.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: when capturing (case 4), if wb_reg_write_i & wb_rd_i != 0 & wb_rd_i == id_r1_i, then ex_reg1_o gets wb_data_i; the same rule applies to r2. This covers register-file write/read in the same cycle.
- Undefined: wb_* ports exist but are ignored; operands come straight from id_reg*_i.

Decomposition:
- Package riscv_pipe_pkg holds:
  - XLEN_DEF = 32
  - REG_IDX_W = 5
  - ALU_OP_W = 4
  - typedef ctrl_t {alu_op, alu_src, mem_read, mem_write, reg_write}
  - constant CTRL_NOP = all zeros
- One natural sub-module: load_use_detect (combinational hazard compare producing load_use).

Test Plan:
- Reset mid-run: assert reset_i asynchronously with EX loaded → all ex_* = 0 and bubble_cnt_o = 0 before the next edge.
- Load-use: EX = lw x5 (mem_read = 1, rd = 5); ID r1 = 5 → stall_o = 1 for one cycle; next EX is a bubble (ex_valid_o = 0); bubble_cnt_o 0→1; the following cycle EX = the dependent instruction with r1 = 5.
- No false stall: EX lw with rd = 0 and ID r1 = 0 → stall_o = 0. EX add x5 (mem_read = 0) and ID r2 = 5 → stall_o = 0, normal capture.
- Flush priority: load_use and flush_i together → stall_o = 0, EX = bubble, counter unchanged.
- Hold: hold_i = 1 for 3 cycles with changing id_* → ex_* unchanged. Release → captures the current id_*.
- With ID_EX_WB_BYPASS_EN: wb_rd = 7, wb_data = 0xDEADBEEF, id_r2 = 7, id_reg2 = 0 → ex_reg2_o = 0xDEADBEEF. Saturation: preload a CNT_W = 2 build to 3 and trigger load_use → stays 3.
